mem_lsu: RTL and testbench

//  MEM-stage load/store unit between the ex_mem pipeline register and mem_wb.

---
 rtl/mem_lsu_pkg.sv | 39 +++
 rtl/mem_lsu_align.sv | 48 ++++
 rtl/mem_lsu.sv | 192 +++++++++++++++++++
 tb/tb_mem_lsu.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_lsu_pkg.sv
// mem_lsu_pkg: aluop codes, FSM and access-size encodings shared by the MEM-stage LSU.
`default_nettype none

package mem_lsu_pkg;

    localparam logic [7:0] EXE_NOP_OP = 8'b0000_0000;
    localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
    localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
    localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
    localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
    localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
    localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
    localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
    localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;
    localparam logic [7:0] EXE_LL_OP  = 8'b1111_0000;
    localparam logic [7:0] EXE_SC_OP  = 8'b1111_1000;

    localparam logic STOP   = 1'b1;
    localparam logic ENABLE = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } acc_size_e;

    function automatic logic is_misaligned(input acc_size_e size, input logic [1:0] lo);
        return ((size == SZ_HALF) && lo[0]) || ((size == SZ_WORD) && (lo != 2'b00));
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_lsu_align.sv
// mem_lsu_align: big-endian lane select, store-data replication and load extraction/extension.
`default_nettype none

module mem_lsu_align
    import mem_lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] st_data,
    input  logic [31:0] ld_data,
    output logic [3:0]  sel,
    output logic [31:0] wdata,
    output logic [31:0] rdata
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        sel   = 4'b1111;
        wdata = st_data;
        rdata = ld_data;
        case (addr_lo)
            2'd0:    ld_byte = ld_data[31:24];
            2'd1:    ld_byte = ld_data[23:16];
            2'd2:    ld_byte = ld_data[15:8];
            default: ld_byte = ld_data[7:0];
        endcase
        ld_half = addr_lo[1] ? ld_data[15:0] : ld_data[31:16];
        case (size)
            SZ_BYTE: begin
                sel   = 4'b1000 >> addr_lo;
                wdata = {4{st_data[7:0]}};
                rdata = {{24{sign_ext & ld_byte[7]}}, ld_byte};
            end
            SZ_HALF: begin
                sel   = addr_lo[1] ? 4'b0011 : 4'b1100;
                wdata = {2{st_data[15:0]}};
                rdata = {{16{sign_ext & ld_half[15]}}, ld_half};
            end
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mem_lsu.sv
// mem_lsu: MEM-stage load/store unit; one bus transaction per memory op, stalls until ack.
// Optional LL/SC support is enabled with `define MEM_LLSC_EN.
`default_nettype none

module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        wd_i,
    input  logic              wreg_i,
    input  logic [31:0]       wdata_i,
    input  logic [31:0]       hi_i,
    input  logic [31:0]       lo_i,
    input  logic              whilo_i,
    input  logic [7:0]        aluop_i,
    input  logic [31:0]       mem_addr_i,
    input  logic [31:0]       reg2_i,
    input  logic              bus_ack_i,
    input  logic [31:0]       bus_rdata_i,
`ifdef MEM_LLSC_EN
    input  logic              llbit_clr_i,
`endif
    output logic              bus_req_o,
    output logic              bus_we_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [3:0]        bus_sel_o,
    output logic [31:0]       bus_wdata_o,
    output logic [4:0]        wd_o,
    output logic              wreg_o,
    output logic [31:0]       wdata_o,
    output logic [31:0]       hi_o,
    output logic [31:0]       lo_o,
    output logic              whilo_o,
    output logic              stallreq_o,
    output logic              align_err_o
);

    lsu_state_e  state;
    logic [31:0] rdata_q;
    acc_size_e   size;
    logic        sign_ext, is_load, is_store, is_sc, llsc_nop;
    logic        mem_op, misaligned, sc_fail, go;
    logic [3:0]  lane_sel;
    logic [31:0] lane_wdata, load_data;
`ifdef MEM_LLSC_EN
    logic        is_ll, llbit;
`endif

    always_comb begin
        size     = SZ_WORD;
        sign_ext = 1'b0;
        is_load  = 1'b0;
        is_store = 1'b0;
        is_sc    = 1'b0;
        llsc_nop = 1'b0;
`ifdef MEM_LLSC_EN
        is_ll    = 1'b0;
`endif
        case (aluop_i)
            EXE_LB_OP:  begin is_load = 1'b1; size = SZ_BYTE; sign_ext = 1'b1; end
            EXE_LBU_OP: begin is_load = 1'b1; size = SZ_BYTE; end
            EXE_LH_OP:  begin is_load = 1'b1; size = SZ_HALF; sign_ext = 1'b1; end
            EXE_LHU_OP: begin is_load = 1'b1; size = SZ_HALF; end
            EXE_LW_OP:  is_load = 1'b1;
            EXE_SB_OP:  begin is_store = 1'b1; size = SZ_BYTE; end
            EXE_SH_OP:  begin is_store = 1'b1; size = SZ_HALF; end
            EXE_SW_OP:  is_store = 1'b1;
`ifdef MEM_LLSC_EN
            EXE_LL_OP:  begin is_load = 1'b1; is_ll = 1'b1; end
            EXE_SC_OP:  begin is_store = 1'b1; is_sc = 1'b1; end
`else
            EXE_LL_OP, EXE_SC_OP: llsc_nop = 1'b1;
`endif
            default: ;
        endcase
    end

    assign mem_op     = is_load | is_store;
    assign misaligned = mem_op & is_misaligned(size, mem_addr_i[1:0]);
`ifdef MEM_LLSC_EN
    assign sc_fail    = is_sc & ~llbit & ~misaligned;
`else
    assign sc_fail    = 1'b0;
`endif
    assign go         = mem_op & ~misaligned & ~sc_fail;

    // Inputs stay frozen in ex_mem while stalled, so both directions share one aligner.
    mem_lsu_align u_align (
        .size     (size),
        .sign_ext (sign_ext),
        .addr_lo  (mem_addr_i[1:0]),
        .st_data  (reg2_i),
        .ld_data  (rdata_q),
        .sel      (lane_sel),
        .wdata    (lane_wdata),
        .rdata    (load_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            bus_req_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= '0;
            bus_sel_o   <= '0;
            bus_wdata_o <= '0;
            rdata_q     <= '0;
            align_err_o <= 1'b0;
        end else begin
            align_err_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    align_err_o <= misaligned;
                    if (go) begin
                        bus_req_o   <= 1'b1;
                        bus_we_o    <= is_store;
                        bus_addr_o  <= {mem_addr_i[ADDR_W-1:2], 2'b00};
                        bus_sel_o   <= lane_sel;
                        bus_wdata_o <= lane_wdata;
                        state       <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (bus_ack_i) begin
                        rdata_q   <= bus_rdata_i;
                        bus_req_o <= 1'b0;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef MEM_LLSC_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            llbit <= 1'b0;
        else if (llbit_clr_i)
            llbit <= 1'b0;
        else if ((state == ST_DONE) && is_ll)
            llbit <= 1'b1;
        else if ((state == ST_DONE) && is_sc)
            llbit <= 1'b0;
    end
`endif

    always_comb begin
        wd_o       = wd_i;
        hi_o       = hi_i;
        lo_o       = lo_i;
        whilo_o    = whilo_i;
        wdata_o    = wdata_i;
        wreg_o     = wreg_i;
        stallreq_o = 1'b0;
        if (!rst) begin
            wreg_o  = 1'b0;
            whilo_o = 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (sc_fail)
                        wdata_o = '0;
                    else if (mem_op || llsc_nop) begin
                        wreg_o     = 1'b0;
                        stallreq_o = go;
                    end
                end
                ST_BUSY: begin
                    wreg_o     = 1'b0;
                    stallreq_o = 1'b1;
                end
                ST_DONE: begin
                    if (is_sc)
                        wdata_o = 32'd1;
                    else if (is_load)
                        wdata_o = load_data;
                    else
                        wreg_o = 1'b0;
                end
                default: wreg_o = 1'b0;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: directed plus randomized checks of mem_lsu against a byte-level reference model.
`default_nettype none

module tb_mem_lsu;
    import mem_lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic [31:0] wdata_i, hi_i, lo_i;
    logic        whilo_i;
    logic [7:0]  aluop_i;
    logic [31:0] mem_addr_i, reg2_i;
    logic        bus_ack_i;
    logic [31:0] bus_rdata_i;
`ifdef MEM_LLSC_EN
    logic        llbit_clr_i;
`endif
    logic        bus_req_o, bus_we_o;
    logic [31:0] bus_addr_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_wdata_o;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o, hi_o, lo_o;
    logic        whilo_o, stallreq_o, align_err_o;

    int   n_checks = 0;
    int   n_fail   = 0;
    logic llbit_m  = 1'b0;

    mem_lsu #(.ADDR_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .wd_i        (wd_i),
        .wreg_i      (wreg_i),
        .wdata_i     (wdata_i),
        .hi_i        (hi_i),
        .lo_i        (lo_i),
        .whilo_i     (whilo_i),
        .aluop_i     (aluop_i),
        .mem_addr_i  (mem_addr_i),
        .reg2_i      (reg2_i),
        .bus_ack_i   (bus_ack_i),
        .bus_rdata_i (bus_rdata_i),
`ifdef MEM_LLSC_EN
        .llbit_clr_i (llbit_clr_i),
`endif
        .bus_req_o   (bus_req_o),
        .bus_we_o    (bus_we_o),
        .bus_addr_o  (bus_addr_o),
        .bus_sel_o   (bus_sel_o),
        .bus_wdata_o (bus_wdata_o),
        .wd_o        (wd_o),
        .wreg_o      (wreg_o),
        .wdata_o     (wdata_o),
        .hi_o        (hi_o),
        .lo_o        (lo_o),
        .whilo_o     (whilo_o),
        .stallreq_o  (stallreq_o),
        .align_err_o (align_err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Reference transaction: called just after a rising edge with the FSM idle.
    task automatic do_mem(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] rt,
                          input logic [31:0] rd, input int waits);
        int n, k;
        logic sgn, ld, st, sc, ll;
        logic [31:0] mask, exp_sel, exp_wd, exp_res, v;
        logic [4:0] wd_pick;
        n = 4; sgn = 0; ld = 0; st = 0; sc = 0; ll = 0;
        case (op)
            EXE_LB_OP:  begin n = 1; sgn = 1; ld = 1; end
            EXE_LBU_OP: begin n = 1; ld = 1; end
            EXE_LH_OP:  begin n = 2; sgn = 1; ld = 1; end
            EXE_LHU_OP: begin n = 2; ld = 1; end
            EXE_LW_OP:  ld = 1;
            EXE_SB_OP:  begin n = 1; st = 1; end
            EXE_SH_OP:  begin n = 2; st = 1; end
            EXE_SW_OP:  st = 1;
            EXE_LL_OP:  begin ld = 1; ll = 1; end
            EXE_SC_OP:  begin st = 1; sc = 1; end
            default: ;
        endcase
        wd_pick    = 5'($urandom);
        aluop_i    = op;
        mem_addr_i = addr;
        reg2_i     = rt;
        wreg_i     = 1'b1;
        wd_i       = wd_pick;
        wdata_i    = $urandom;
        bus_ack_i  = 1'b0;
        @(negedge clk);
        chk("idle_bus_req", bus_req_o, 0);
        if ((addr % n) != 0) begin
            chk("misal_stall", stallreq_o, 0);
            chk("misal_wreg", wreg_o, 0);
            next_cycle();
            aluop_i = EXE_NOP_OP;
            @(negedge clk);
            chk("misal_err_pulse", align_err_o, 1);
            chk("misal_no_req", bus_req_o, 0);
            next_cycle();
            @(negedge clk);
            chk("misal_err_clear", align_err_o, 0);
            next_cycle();
            return;
        end
        if (sc && !llbit_m) begin
            chk("scfail_stall", stallreq_o, 0);
            chk("scfail_wreg", wreg_o, 1);
            chk("scfail_wdata", wdata_o, 0);
            next_cycle();
            aluop_i = EXE_NOP_OP;
            @(negedge clk);
            chk("scfail_no_req", bus_req_o, 0);
            next_cycle();
            return;
        end
        chk("idle_stall", stallreq_o, 1);
        chk("idle_wreg", wreg_o, 0);
        k       = int'(addr[1:0]);
        mask    = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
        exp_sel = ((32'd1 << n) - 32'd1) << (4 - n - k);
        v       = rt & mask;
        exp_wd  = 32'd0;
        for (int i = 0; i < 4 / n; i++) exp_wd |= v << (8 * n * i);
        exp_res = (rd >> (8 * (4 - n - k))) & mask;
        if (sgn && exp_res[8 * n - 1]) exp_res |= ~mask;
        next_cycle();
        for (int c = 0; c <= waits; c++) begin
            bus_ack_i   = (c == waits);
            bus_rdata_i = (c == waits) ? rd : $urandom;
            @(negedge clk);
            chk("busy_req", bus_req_o, 1);
            chk("busy_we", bus_we_o, st);
            chk("busy_addr", bus_addr_o, {addr[31:2], 2'b00});
            chk("busy_sel", bus_sel_o, exp_sel);
            if (st) chk("busy_wdata", bus_wdata_o, exp_wd);
            chk("busy_stall", stallreq_o, 1);
            chk("busy_wreg", wreg_o, 0);
            next_cycle();
        end
        bus_ack_i   = 1'b0;
        bus_rdata_i = $urandom;
        @(negedge clk);
        chk("done_stall", stallreq_o, 0);
        chk("done_req", bus_req_o, 0);
        chk("done_wreg", wreg_o, (ld || sc) ? 1 : 0);
        chk("done_wd", wd_o, wd_pick);
        if (ld) chk("done_load_data", wdata_o, exp_res);
        if (sc) chk("done_sc_data", wdata_o, 1);
        if (ll) llbit_m = 1'b1;
        if (sc) llbit_m = 1'b0;
        next_cycle();
        aluop_i = EXE_NOP_OP;
    endtask

    initial begin
        logic [7:0]  ops [8];
        logic [31:0] r0, r1, r2;
        ops = '{EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP, EXE_SB_OP, EXE_SH_OP, EXE_SW_OP};
        rst = 1'b0;
        wd_i = 5'd3; wreg_i = 1'b1; wdata_i = 32'h1111_2222;
        hi_i = 32'h0; lo_i = 32'h0; whilo_i = 1'b1;
        aluop_i = EXE_LW_OP; mem_addr_i = 32'h104; reg2_i = 32'h0;
        bus_ack_i = 1'b0; bus_rdata_i = 32'h0;
`ifdef MEM_LLSC_EN
        llbit_clr_i = 1'b0;
`endif
        @(negedge clk);
        chk("rst_bus_req", bus_req_o, 0);
        chk("rst_bus_we", bus_we_o, 0);
        chk("rst_bus_addr", bus_addr_o, 0);
        chk("rst_bus_sel", bus_sel_o, 0);
        chk("rst_bus_wdata", bus_wdata_o, 0);
        chk("rst_align_err", align_err_o, 0);
        chk("rst_stall", stallreq_o, 0);
        chk("rst_wreg", wreg_o, 0);
        chk("rst_whilo", whilo_o, 0);
        next_cycle();
        rst = 1'b1;
        aluop_i = EXE_NOP_OP;

        // Pass-through with a stray ack outside a transaction.
        r0 = $urandom; r1 = $urandom; r2 = $urandom;
        wd_i = 5'd17; wreg_i = 1'b1; wdata_i = r0; hi_i = r1; lo_i = r2; whilo_i = 1'b1;
        bus_ack_i = 1'b1;
        @(negedge clk);
        chk("pt_wd", wd_o, 17);
        chk("pt_wreg", wreg_o, 1);
        chk("pt_wdata", wdata_o, r0);
        chk("pt_hi", hi_o, r1);
        chk("pt_lo", lo_o, r2);
        chk("pt_whilo", whilo_o, 1);
        chk("pt_stall", stallreq_o, 0);
        next_cycle();
        @(negedge clk);
        chk("stray_ack_req", bus_req_o, 0);
        next_cycle();
        bus_ack_i = 1'b0; whilo_i = 1'b0;

        do_mem(EXE_LW_OP,  32'h100, 32'h0, 32'hDEADBEEF, 1);
        do_mem(EXE_LB_OP,  32'h103, 32'h0, 32'h000000F0, 0);
        do_mem(EXE_LBU_OP, 32'h103, 32'h0, 32'h000000F0, 0);
        do_mem(EXE_SH_OP,  32'h202, 32'h1234ABCD, 32'h0, 0);
        do_mem(EXE_LW_OP,  32'h101, 32'h0, 32'h0, 0);
        do_mem(EXE_LH_OP,  32'h200, 32'h0, 32'h8001_7FFF, 2);

        // Asynchronous reset while BUSY; the later ack must be ignored.
        aluop_i = EXE_LW_OP; mem_addr_i = 32'h400; wreg_i = 1'b1;
        next_cycle();
        @(negedge clk);
        chk("pre_rst_req", bus_req_o, 1);
        #1 rst = 1'b0;
        #1;
        chk("midrst_req", bus_req_o, 0);
        chk("midrst_stall", stallreq_o, 0);
        chk("midrst_wreg", wreg_o, 0);
        bus_ack_i = 1'b1; bus_rdata_i = 32'hCAFE_F00D;
        next_cycle();
        next_cycle();
        rst = 1'b1;
        aluop_i = EXE_NOP_OP;
        @(negedge clk);
        chk("postrst_req", bus_req_o, 0);
        chk("postrst_stall", stallreq_o, 0);
        next_cycle();
        @(negedge clk);
        chk("postrst_ack_ignored", bus_req_o, 0);
        next_cycle();
        bus_ack_i = 1'b0;
        do_mem(EXE_LHU_OP, 32'h402, 32'h0, 32'h1234_9ABC, 0);

`ifdef MEM_LLSC_EN
        do_mem(EXE_LL_OP, 32'h300, 32'h0, 32'h5555_AAAA, 0);
        do_mem(EXE_SC_OP, 32'h300, 32'h7777_8888, 32'h0, 1);
        do_mem(EXE_SC_OP, 32'h300, 32'h7777_8888, 32'h0, 0);
        do_mem(EXE_LL_OP, 32'h300, 32'h0, 32'h0102_0304, 0);
        llbit_clr_i = 1'b1;
        next_cycle();
        llbit_clr_i = 1'b0;
        llbit_m = 1'b0;
        do_mem(EXE_SC_OP, 32'h300, 32'h7777_8888, 32'h0, 0);
`else
        aluop_i = EXE_LL_OP; mem_addr_i = 32'h300; wreg_i = 1'b1;
        @(negedge clk);
        chk("ll_nop_wreg", wreg_o, 0);
        chk("ll_nop_stall", stallreq_o, 0);
        next_cycle();
        aluop_i = EXE_SC_OP;
        @(negedge clk);
        chk("ll_nop_req", bus_req_o, 0);
        chk("sc_nop_wreg", wreg_o, 0);
        next_cycle();
        @(negedge clk);
        chk("sc_nop_req", bus_req_o, 0);
        next_cycle();
        aluop_i = EXE_NOP_OP;
`endif

        for (int t = 0; t < 40; t++) begin
            do_mem(ops[$urandom_range(0, 7)], $urandom, $urandom, $urandom, $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
